// File: rtl/e_md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU over a
// fixed number of busy cycles and performs single-cycle MTHI/MTLO writes.
module e_md_unit #(
   parameter int WIDTH    = 32,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hilo_sel,
   output logic [WIDTH-1:0] hilo_out,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shadow_hi;
   logic [WIDTH-1:0] shadow_lo;

   logic [2*WIDTH-1:0] a_sext, b_sext, a_zext, b_zext;
   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, d_safe_s, d_safe_u;
   logic [WIDTH-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;
   logic [WIDTH-1:0]   next_hi, next_lo;

   // Low 2*WIDTH bits of a product of sign/zero-extended operands give the
   // exact signed/unsigned full-width result.
   assign a_sext = {{WIDTH{a[WIDTH-1]}}, a};
   assign b_sext = {{WIDTH{b[WIDTH-1]}}, b};
   assign a_zext = {{WIDTH{1'b0}}, a};
   assign b_zext = {{WIDTH{1'b0}}, b};
   assign prod_s = a_sext * b_sext;
   assign prod_u = a_zext * b_zext;

   // Signed divide on magnitudes avoids the most-negative / -1 overflow:
   // its magnitude 2^(WIDTH-1) still fits as an unsigned value.
   assign a_neg    = a[WIDTH-1];
   assign b_neg    = b[WIDTH-1];
   assign a_mag    = a_neg ? -a : a;
   assign b_mag    = b_neg ? -b : b;
   assign d_safe_s = (b == '0) ? WIDTH'(1) : b_mag;
   assign d_safe_u = (b == '0) ? WIDTH'(1) : b;
   assign q_mag    = a_mag / d_safe_s;
   assign r_mag    = a_mag % d_safe_s;
   assign q_s      = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign r_s      = a_neg ? -r_mag : r_mag;
   assign q_u      = a / d_safe_u;
   assign r_u      = a % d_safe_u;

   always_comb begin
      next_hi = hi;
      next_lo = lo;
      case (md_op)
         OP_MULT: begin
            next_hi = prod_s[2*WIDTH-1:WIDTH];
            next_lo = prod_s[WIDTH-1:0];
         end
         OP_MULTU: begin
            next_hi = prod_u[2*WIDTH-1:WIDTH];
            next_lo = prod_u[WIDTH-1:0];
         end
         OP_DIV: begin
            if (b != '0) begin
               next_hi = r_s;
               next_lo = q_s;
            end
         end
         OP_DIVU: begin
            if (b != '0) begin
               next_hi = r_u;
               next_lo = q_u;
            end
         end
         default: ;
      endcase
   end

   // Start is only honoured in IDLE; the counter commit edge is the one
   // where it steps from 1 to 0, giving exactly N busy cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         shadow_hi <= '0;
         shadow_lo <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  case (md_op)
                     OP_MULT, OP_MULTU: begin
                        shadow_hi <= next_hi;
                        shadow_lo <= next_lo;
                        cnt       <= CW'(MULT_CYC);
                        busy      <= 1'b1;
                        state     <= RUN;
                     end
                     OP_DIV, OP_DIVU: begin
                        shadow_hi <= next_hi;
                        shadow_lo <= next_lo;
                        cnt       <= CW'(DIV_CYC);
                        busy      <= 1'b1;
                        state     <= RUN;
                     end
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               cnt <= cnt - CW'(1);
               if (cnt <= CW'(1)) begin
                  hi    <= shadow_hi;
                  lo    <= shadow_lo;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign hilo_out = hilo_sel ? lo : hi;

endmodule

// File: tb/tb_e_md_unit.sv
// Scoreboarded random + directed bench for e_md_unit; commits are checked by
// a monitor that pops expected HI/LO and busy length when busy drops.
module tb_e_md_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk, reset, start, start1, hilo_sel;
   logic [2:0]  md_op;
   logic [31:0] a, b;
   logic [31:0] hilo_out, hi, lo;
   logic        busy;
   logic [31:0] hilo_out1, hi1, lo1;
   logic        busy1;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_hi, m_lo;

   e_md_unit #(.WIDTH(32), .MULT_CYC(MC), .DIV_CYC(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
      .hilo_sel(hilo_sel), .hilo_out(hilo_out), .busy(busy), .hi(hi), .lo(lo)
   );

   e_md_unit #(.WIDTH(32), .MULT_CYC(1), .DIV_CYC(2)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .md_op(md_op), .a(a), .b(b),
      .hilo_sel(hilo_sel), .hilo_out(hilo_out1), .busy(busy1), .hi(hi1), .lo(lo1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   function automatic void model_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                    output logic [31:0] rh, output logic [31:0] rl);
      longint          sx, sy, p, q, r;
      longint unsigned ux, uy, up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'(x);
      uy = longint'(y);
      rh = cur_hi;
      rl = cur_lo;
      case (op)
         3'd1: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
         3'd2: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
         3'd3: if (y != 0) begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
         3'd4: if (y != 0) begin up = ux / uy; rl = up[31:0]; up = ux % uy; rh = up[31:0]; end
         default: ;
      endcase
   endfunction

   // Monitor: measure each busy run and check the committed result at its end.
   int run_len   = 0;
   bit prev_busy = 0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         run_len   = 0;
         prev_busy = 0;
      end else begin
         if (busy) run_len++;
         else if (prev_busy) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_commit: got hi=0x%08h lo=0x%08h, expected no commit", hi, lo);
            end else begin
               e = exp_q.pop_front();
               check_output("commit_hi", hi, e.hi);
               check_output("commit_lo", lo, e.lo);
               check_output("busy_len", 32'(run_len), 32'(e.cycles));
            end
            run_len = 0;
         end
         prev_busy = busy;
      end
   end

   // Launch one long op, optionally poke start during RUN, wait for commit.
   task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input bit pulse, input logic [2:0] p_op, input logic [31:0] p_a);
      logic [31:0] eh, el;
      exp_t        e;
      int          k;
      model_op(op, x, y, m_hi, m_lo, eh, el);
      e.hi = eh;
      e.lo = el;
      e.cycles = (op <= 3'd2) ? MC : DC;
      exp_q.push_back(e);
      md_op = op; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      if (pulse) begin
         md_op = p_op; a = p_a; b = $urandom; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0; md_op = 3'd0;
         check_output("ignored_hi", hi, m_hi);
         check_output("ignored_lo", lo, m_lo);
         check_output("busy_in_run", {31'd0, busy}, 32'd1);
      end
      k = 0;
      while (busy && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (busy) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", k);
      end
      m_hi = eh;
      m_lo = el;
      hilo_sel = 1'($urandom_range(0, 1));
      #1 check_output("hilo_out", hilo_out, hilo_sel ? m_lo : m_hi);
   endtask

   task automatic move_to(input logic [2:0] op, input logic [31:0] x);
      md_op = op; a = x; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      if (op == 3'd5) m_hi = x;
      if (op == 3'd6) m_lo = x;
      check_output("mt_hi", hi, m_hi);
      check_output("mt_lo", lo, m_lo);
      check_output("mt_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] x, y;
      logic [2:0]  op;
      int          r;
      reset = 1'b1; start = 1'b0; start1 = 1'b0; md_op = 3'd0;
      a = '0; b = '0; hilo_sel = 1'b0;
      m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_output("reset_hi", hi, 32'd0);
      check_output("reset_lo", lo, 32'd0);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;

      // Reset mid-run discards the operation.
      move_to(3'd5, 32'h55);
      move_to(3'd6, 32'h66);
      md_op = 3'd1; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check_output("midreset_busy", {31'd0, busy}, 32'd0);
      check_output("midreset_hi", hi, 32'd0);
      check_output("midreset_lo", lo, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      repeat (8) @(posedge clk);
      #1;
      check_output("postreset_hi", hi, 32'd0);
      check_output("postreset_lo", lo, 32'd0);
      check_output("postreset_busy", {31'd0, busy}, 32'd0);

      // Directed arithmetic and boundary cases.
      apply_stimulus(3'd1, 32'hFFFF_FFFF, 32'h2, 0, 3'd0, 32'd0);
      check_output("mult_hi", hi, 32'hFFFF_FFFF);
      check_output("mult_lo", lo, 32'hFFFF_FFFE);
      apply_stimulus(3'd2, 32'hFFFF_FFFF, 32'h2, 0, 3'd0, 32'd0);
      check_output("multu_hi", hi, 32'h1);
      check_output("multu_lo", lo, 32'hFFFF_FFFE);
      apply_stimulus(3'd3, 32'hFFFF_FFF9, 32'h2, 0, 3'd0, 32'd0);
      check_output("div_neg_hi", hi, 32'hFFFF_FFFF);
      check_output("div_neg_lo", lo, 32'hFFFF_FFFD);
      apply_stimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 32'd0);
      check_output("div_ovf_hi", hi, 32'h0);
      check_output("div_ovf_lo", lo, 32'h8000_0000);
      move_to(3'd5, 32'h11);
      move_to(3'd6, 32'h22);
      apply_stimulus(3'd3, 32'h1234, 32'h0, 0, 3'd0, 32'd0);
      check_output("div0_hi", hi, 32'h11);
      check_output("div0_lo", lo, 32'h22);

      // MTHI during a DIVU run is dropped; afterwards it lands in one cycle.
      apply_stimulus(3'd4, 32'd100, 32'd7, 1, 3'd5, 32'hDEAD);
      check_output("divu_hi", hi, 32'd2);
      check_output("divu_lo", lo, 32'd14);
      move_to(3'd5, 32'hDEAD);

      move_to(3'd5, 32'hA);
      move_to(3'd6, 32'hB);
      hilo_sel = 1'b0;
      #1 check_output("sel_hi", hilo_out, 32'hA);
      hilo_sel = 1'b1;
      #1 check_output("sel_lo", hilo_out, 32'hB);

      // Single-cycle multiply instance: busy for exactly one cycle.
      md_op = 3'd1; a = 32'hFFFF_FFFF; b = 32'h2; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; md_op = 3'd0;
      check_output("mc1_busy_on", {31'd0, busy1}, 32'd1);
      @(posedge clk); #1;
      check_output("mc1_busy_off", {31'd0, busy1}, 32'd0);
      check_output("mc1_hi", hi1, 32'hFFFF_FFFF);
      check_output("mc1_lo", lo1, 32'hFFFF_FFFE);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         x = $urandom;
         y = $urandom;
         if ($urandom_range(0, 3) == 0) y = 32'd0;
         else if ($urandom_range(0, 7) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
         else if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(8, 28);
         if (r <= 5) begin
            op = 3'(1 + (r % 4));
            apply_stimulus(op, x, y, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
         end else if (r <= 7) begin
            move_to((r == 6) ? 3'd5 : 3'd6, x);
         end else begin
            md_op = (r == 8) ? 3'd0 : 3'd7; a = x; b = y; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; md_op = 3'd0;
            check_output("nop_hi", hi, m_hi);
            check_output("nop_lo", lo, m_lo);
            check_output("nop_busy", {31'd0, busy}, 32'd0);
         end
      end

      repeat (3) @(posedge clk);
      #1 check_output("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/e_md_unit.md
Name: e_md_unit

Overview:
- Parametrised multiply/divide unit for the E stage. It owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU with configurable multi-cycle latency, plus MTHI/MTLO single-cycle writes.
- Provides the HI/LO read path, selected per instruction, feeding the E-stage result mux and the HILO forwarding source.
- Asserts busy so the hazard unit can stall MD-class instructions in D.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_CYC, 5: busy cycles for MULT/MULTU (>=1).
- DIV_CYC, 10: busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch md_op this cycle (E-stage instruction is an MD op).
- md_op  in  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; others treated as NONE.
- a  in  WIDTH  rs operand (already forwarded).
- b  in  WIDTH  rt operand (already forwarded).
- hilo_sel  in  1  read select: 0 HI, 1 LO.
- hilo_out  out  WIDTH  selected committed HI or LO (combinational).
- busy  out  1  operation in flight.
- hi  out  WIDTH  committed HI.
- lo  out  WIDTH  committed LO.

Behaviour:
- Reset (async, any time, including mid-operation):
  - hi, lo, and the shadow result registers go to 0.
  - busy=0, counter=0, FSM=IDLE.
  - The in-flight operation is discarded.
- FSM states: IDLE, RUN.
- Launching from IDLE:
  - start=1 with md_op in {1..4} samples a and b at the edge, computes the full result into shadow registers, loads the counter with MULT_CYC or DIV_CYC, and moves to RUN.
  - busy=1 from the following cycle.
- RUN:
  - The counter decrements each edge.
  - On the edge where the counter reaches 0: shadow is copied to hi/lo, FSM returns to IDLE, busy=0 in the next cycle.
  - Total: busy is high for exactly N cycles; new hi/lo are visible in the cycle busy first drops.
- start while RUN: ignored for every md_op, including MTHI/MTLO. The hazard unit must stall; the bench checks that no state changes.
- MTHI/MTLO in IDLE: hi (or lo) takes a at the next edge; busy stays 0; latency 1.
- Arithmetic rules:
  - MULT: signed WIDTH x WIDTH -> 2*WIDTH. hi = upper half, lo = lower half.
  - MULTU: same, unsigned.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide boundaries:
  - DIV with a = most-negative and b = -1: lo = most-negative, hi = 0. No trap.
  - Divide by zero (b=0): the operation runs the full DIV_CYC, then leaves hi/lo unchanged (the shadow is loaded with the current hi/lo).
- Read path:
  - hilo_out = hilo_sel ? lo : hi, always reflecting committed values.
  - During RUN, hilo_out shows the old values; readers must be stalled by busy.
- Simultaneous events:
  - Commit edge with start=1 in the same cycle: the FSM is still RUN, so start is ignored.
  - start accepted the cycle after busy drops.
- md_op NONE or invalid with start=1: no effect.

Test Plan:
- Reset mid-RUN: launch MULT a=3, b=4; assert reset on cycle 2 -> hi=lo=0, busy=0 immediately; no commit after reset releases.
- MULT signed: a=0xFFFFFFFF (-1), b=0x00000002 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU: a=0xFFFFFFFF, b=0x00000002 -> after 5 cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV boundary cases:
  - a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - b=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo unchanged.
- Busy blocking: during DIVU run, pulse start with MTHI a=0xDEAD -> ignored; after commit, MTHI a=0xDEAD -> hi=0xDEAD next edge, busy stays 0.
- Read select: hi=0xA, lo=0xB; toggle hilo_sel -> hilo_out 0xA/0xB combinationally; with MULT_CYC=1 override, busy pulses exactly 1 cycle.
